// File: rtl/rv32i_encoder_pkg.sv
// Shared RV32I constants for the encoder slice.
// Contents: opcode class constants (OP_*), {funct7,funct3} constants (F_*),
// encoder error codes (ENC_ERR_*) and the registered result record.
// Optional feature elsewhere in the slice: ENC_STATS_EN (statistics counters).
package rv32i_encoder_pkg;

  // Opcode classes
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_ILD = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_U   = 7'b0110111;
  localparam logic [6:0] OP_J   = 7'b1101111;
  localparam logic [6:0] OP_IJR = 7'b1100111;

  // R-type {funct7, funct3}
  localparam logic [9:0] F_ADD  = 10'b0000000_000;
  localparam logic [9:0] F_SUB  = 10'b0100000_000;
  localparam logic [9:0] F_SLL  = 10'b0000000_001;
  localparam logic [9:0] F_SLT  = 10'b0000000_010;
  localparam logic [9:0] F_SLTU = 10'b0000000_011;
  localparam logic [9:0] F_XOR  = 10'b0000000_100;
  localparam logic [9:0] F_SRL  = 10'b0000000_101;
  localparam logic [9:0] F_SRA  = 10'b0100000_101;
  localparam logic [9:0] F_OR   = 10'b0000000_110;
  localparam logic [9:0] F_AND  = 10'b0000000_111;

  // I-type ALU
  localparam logic [9:0] F_ADDI  = 10'b0000000_000;
  localparam logic [9:0] F_SLTI  = 10'b0000000_010;
  localparam logic [9:0] F_SLTIU = 10'b0000000_011;
  localparam logic [9:0] F_XORI  = 10'b0000000_100;
  localparam logic [9:0] F_ORI   = 10'b0000000_110;
  localparam logic [9:0] F_ANDI  = 10'b0000000_111;
  localparam logic [9:0] F_SLLI  = 10'b0000000_001;
  localparam logic [9:0] F_SRLI  = 10'b0000000_101;
  localparam logic [9:0] F_SRAI  = 10'b0100000_101;

  // Loads, stores, branches, JALR
  localparam logic [9:0] F_LB   = 10'b0000000_000;
  localparam logic [9:0] F_LH   = 10'b0000000_001;
  localparam logic [9:0] F_LW   = 10'b0000000_010;
  localparam logic [9:0] F_LBU  = 10'b0000000_100;
  localparam logic [9:0] F_LHU  = 10'b0000000_101;
  localparam logic [9:0] F_SB   = 10'b0000000_000;
  localparam logic [9:0] F_SH   = 10'b0000000_001;
  localparam logic [9:0] F_SW   = 10'b0000000_010;
  localparam logic [9:0] F_BEQ  = 10'b0000000_000;
  localparam logic [9:0] F_BNE  = 10'b0000000_001;
  localparam logic [9:0] F_BLT  = 10'b0000000_100;
  localparam logic [9:0] F_BGE  = 10'b0000000_101;
  localparam logic [9:0] F_BLTU = 10'b0000000_110;
  localparam logic [9:0] F_BGEU = 10'b0000000_111;
  localparam logic [9:0] F_JALR = 10'b0000000_000;

  // Error codes, listed in check priority order
  localparam logic [2:0] ENC_ERR_NONE  = 3'd0;
  localparam logic [2:0] ENC_ERR_OP    = 3'd1;
  localparam logic [2:0] ENC_ERR_FUNC  = 3'd2;
  localparam logic [2:0] ENC_ERR_RANGE = 3'd3;
  localparam logic [2:0] ENC_ERR_ALIGN = 3'd4;

  // One encoded result as held in the output and skid registers
  typedef struct packed {
    logic [31:0] instr;
    logic        err;
    logic [2:0]  err_code;
  } enc_res_t;

endpackage

// File: rtl/rv32i_encoder_if.sv
// Field-in / word-out bus of the RV32I encoder.
// slave  : encoder side (takes fields, produces words).
// master : producer/consumer side.
// Both handshakes use strict valid/ready: a transfer happens on a rising edge
// where valid && ready; once valid is raised the payload is held stable until
// that transfer, and valid never waits on ready.
interface rv32i_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  op;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [9:0]  func;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic        err;
  logic [2:0]  err_code;

  modport slave (
    input  in_valid, op, rs1, rs2, rd, func, imm, out_ready,
    output in_ready, out_valid, instr, err, err_code
  );
  modport master (
    output in_valid, op, rs1, rs2, rd, func, imm, out_ready,
    input  in_ready, out_valid, instr, err, err_code
  );
endinterface

// File: rtl/rv32i_enc_core.sv
// Combinational RV32I field checker and packer.
// Inputs : i_op, i_rs1, i_rs2, i_rd, i_func ({funct7,funct3}), i_imm.
// Outputs: o_instr (zero when illegal), o_err, o_err_code.
module rv32i_enc_core
  import rv32i_encoder_pkg::*;
(
  input  logic [6:0]  i_op,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  input  logic [9:0]  i_func,
  input  logic [31:0] i_imm,
  output logic [31:0] o_instr,
  output logic        o_err,
  output logic [2:0]  o_err_code
);
  logic [6:0]  w_f7;
  logic [2:0]  w_f3;
  logic        w_op_ok, w_func_ok, w_range_ok, w_align_ok;
  logic        w_imm12_ok, w_imm13_ok, w_imm21_ok;
  logic [31:0] w_word;

  assign w_f7 = i_func[9:3];
  assign w_f3 = i_func[2:0];

  // Sign-consistency of the upper bits = fits in an N-bit signed field
  assign w_imm12_ok = (&i_imm[31:11]) | ~(|i_imm[31:11]);
  assign w_imm13_ok = (&i_imm[31:12]) | ~(|i_imm[31:12]);
  assign w_imm21_ok = (&i_imm[31:20]) | ~(|i_imm[31:20]);

  always_comb begin
    w_op_ok    = 1'b1;
    w_func_ok  = 1'b1;
    w_range_ok = 1'b1;
    w_align_ok = 1'b1;
    w_word     = '0;
    case (i_op)
      OP_R: begin
        w_func_ok = i_func inside {F_ADD, F_SUB, F_SLL, F_SLT, F_SLTU,
                                   F_XOR, F_SRL, F_SRA, F_OR, F_AND};
        w_word    = {w_f7, i_rs2, i_rs1, w_f3, i_rd, i_op};
      end
      OP_I: begin
        if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
          // Shifts: funct7 lives in imm[11:5]; the rest of imm must agree
          w_func_ok  = i_func inside {F_SLLI, F_SRLI, F_SRAI};
          w_range_ok = (i_imm[31:5] == {20'd0, w_f7});
        end else begin
          w_func_ok  = i_func inside {F_ADDI, F_SLTI, F_SLTIU, F_XORI, F_ORI, F_ANDI};
          w_range_ok = w_imm12_ok;
        end
        w_word = {i_imm[11:0], i_rs1, w_f3, i_rd, i_op};
      end
      OP_ILD: begin
        w_func_ok  = i_func inside {F_LB, F_LH, F_LW, F_LBU, F_LHU};
        w_range_ok = w_imm12_ok;
        w_word     = {i_imm[11:0], i_rs1, w_f3, i_rd, i_op};
      end
      OP_IJR: begin
        w_func_ok  = (i_func == F_JALR);
        w_range_ok = w_imm12_ok;
        w_word     = {i_imm[11:0], i_rs1, w_f3, i_rd, i_op};
      end
      OP_S: begin
        w_func_ok  = i_func inside {F_SB, F_SH, F_SW};
        w_range_ok = w_imm12_ok;
        w_word     = {i_imm[11:5], i_rs2, i_rs1, w_f3, i_imm[4:0], i_op};
      end
      OP_B: begin
        w_func_ok  = i_func inside {F_BEQ, F_BNE, F_BLT, F_BGE, F_BLTU, F_BGEU};
        // Top of the 13-bit range (4095) is odd, so it is not a legal target
        w_range_ok = w_imm13_ok && (i_imm != 32'h0000_0FFF);
        w_align_ok = ~i_imm[0];
        w_word     = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, w_f3,
                      i_imm[4:1], i_imm[11], i_op};
      end
      OP_U: begin
        w_word = {i_imm[31:12], i_rd, i_op};
      end
      OP_J: begin
        w_range_ok = w_imm21_ok && (i_imm != 32'h000F_FFFF);
        w_align_ok = ~i_imm[0];
        w_word     = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_op};
      end
      default: w_op_ok = 1'b0;
    endcase
  end

  always_comb begin
    if (!w_op_ok)         o_err_code = ENC_ERR_OP;
    else if (!w_func_ok)  o_err_code = ENC_ERR_FUNC;
    else if (!w_range_ok) o_err_code = ENC_ERR_RANGE;
    else if (!w_align_ok) o_err_code = ENC_ERR_ALIGN;
    else                  o_err_code = ENC_ERR_NONE;
  end

  assign o_err   = (o_err_code != ENC_ERR_NONE);
  assign o_instr = o_err ? 32'h0000_0000 : w_word;

endmodule

// File: rtl/rv32i_encoder.sv
// Streaming RV32I instruction encoder: fields in, 32-bit word out, one-cycle
// latency, full throughput, output register plus one skid register.
// Ports: clk, rst (sync, active high), bus (rv32i_encoder_if.slave),
//        n_ok / n_err (CNT_W-bit saturating counters, only with ENC_STATS_EN).
// Optional feature macro: ENC_STATS_EN.
module rv32i_encoder
  import rv32i_encoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  rv32i_encoder_if.slave     bus
`ifdef ENC_STATS_EN
  ,
  output logic [CNT_W-1:0]   n_ok,
  output logic [CNT_W-1:0]   n_err
`endif
);
  enc_res_t r_out, r_skid;
  enc_res_t w_core;
  logic     r_out_valid, r_skid_valid, r_in_ready;
  logic     w_accept, w_drain, w_out_free, w_skid_valid_nxt;

  rv32i_enc_core u_core (
    .i_op       (bus.op),
    .i_rs1      (bus.rs1),
    .i_rs2      (bus.rs2),
    .i_rd       (bus.rd),
    .i_func     (bus.func),
    .i_imm      (bus.imm),
    .o_instr    (w_core.instr),
    .o_err      (w_core.err),
    .o_err_code (w_core.err_code)
  );

  assign w_accept   = bus.in_valid && r_in_ready;
  assign w_drain    = r_out_valid && bus.out_ready;
  assign w_out_free = !r_out_valid || w_drain;
  // When the output frees up the skid always empties into it; in_ready was
  // low while the skid was full, so no new word can land there that cycle.
  assign w_skid_valid_nxt = w_out_free ? 1'b0 : (r_skid_valid || w_accept);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out        <= '0;
      r_skid_valid <= 1'b0;
      r_skid       <= '0;
      r_in_ready   <= 1'b1;
    end else begin
      if (w_out_free) begin
        if (r_skid_valid) begin
          r_out       <= r_skid;
          r_out_valid <= 1'b1;
        end else if (w_accept) begin
          r_out       <= w_core;
          r_out_valid <= 1'b1;
        end else begin
          r_out_valid <= 1'b0;
        end
      end else if (w_accept) begin
        r_skid <= w_core;
      end
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= !w_skid_valid_nxt;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.instr     = r_out.instr;
  assign bus.err       = r_out.err;
  assign bus.err_code  = r_out.err_code;

`ifdef ENC_STATS_EN
  logic [CNT_W-1:0] r_n_ok, r_n_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_n_ok  <= '0;
      r_n_err <= '0;
    end else if (w_drain) begin
      if (r_out.err) begin
        if (r_n_err != {CNT_W{1'b1}}) r_n_err <= r_n_err + 1'b1;
      end else begin
        if (r_n_ok != {CNT_W{1'b1}}) r_n_ok <= r_n_ok + 1'b1;
      end
    end
  end

  assign n_ok  = r_n_ok;
  assign n_err = r_n_err;
`endif

endmodule

// File: tb/tb_rv32i_encoder.sv
// Self-checking bench for rv32i_encoder: vector table through a scoreboard,
// plus hand-written backpressure and reset-while-full sequences.
module tb_rv32i_encoder;
  import rv32i_encoder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  rv32i_encoder_if ifc();

`ifdef ENC_STATS_EN
  logic [15:0] n_ok, n_err;
`endif

  rv32i_encoder #(.CNT_W(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (ifc)
`ifdef ENC_STATS_EN
    ,
    .n_ok  (n_ok),
    .n_err (n_err)
`endif
  );

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [4:0]  rs1, rs2, rd;
    logic [9:0]  func;
    logic [31:0] imm;
    logic [31:0] e_instr;
    logic [2:0]  e_code;
  } vec_t;

  vec_t        vecs[$];
  logic [35:0] exp_q[$];   // {instr, err, err_code}
  logic [35:0] cur_exp;
  int          errors = 0;
  int          checks = 0;
  int          exp_ok = 0;
  int          exp_err = 0;

  function automatic vec_t mk(string n, logic [6:0] op, logic [4:0] rs1, logic [4:0] rs2,
                              logic [4:0] rd, logic [9:0] f, logic [31:0] imm,
                              logic [31:0] ei, logic [2:0] ec);
    vec_t v;
    v.name = n; v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
    v.func = f; v.imm = imm; v.e_instr = ei; v.e_code = ec;
    return v;
  endfunction

  task automatic check(string name, logic [35:0] act, logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Sampled on the falling edge: a handshake seen here completes at the next
  // rising edge.
  always @(negedge clk) begin : scoreboard
    logic [35:0] e;
    if (rst) begin
      exp_q.delete();
      exp_ok  = 0;
      exp_err = 0;
    end else begin
      if (ifc.out_valid && ifc.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %h expected no output", ifc.instr);
        end else begin
          e = exp_q.pop_front();
          check("output", {ifc.instr, ifc.err, ifc.err_code}, e);
          if (e[3]) exp_err++; else exp_ok++;
        end
      end
      if (ifc.in_valid && ifc.in_ready) exp_q.push_back(cur_exp);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    ifc.in_valid = 1'b1;
    ifc.op = v.op; ifc.rs1 = v.rs1; ifc.rs2 = v.rs2; ifc.rd = v.rd;
    ifc.func = v.func; ifc.imm = v.imm;
    cur_exp = {v.e_instr, (v.e_code != 3'd0), v.e_code};
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input vec_t v, input bit rnd);
    int n;
    n = 0;
    drive(v);
    if (rnd) ifc.out_ready = ($urandom_range(0, 3) != 0);
    forever begin
      @(negedge clk);
      if (ifc.in_ready) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL accept_timeout(%s): got in_ready=0 expected 1 within 50 cycles", v.name);
        break;
      end
      @(posedge clk); #1;
      if (rnd) ifc.out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain(string tag);
    int n;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    for (n = 0; n < 40; n++) begin
      @(negedge clk); #1;
      if (exp_q.size() == 0 && !ifc.out_valid) break;
    end
    check({tag, "_drained"}, {35'd0, (exp_q.size() == 0 && !ifc.out_valid)}, 36'd1);
    @(posedge clk); #1;
  endtask

  task automatic check_idle(string tag);
    check({tag, "_state"}, {ifc.out_valid, ifc.in_ready, ifc.instr, ifc.err, ifc.err_code},
          {1'b0, 1'b1, 32'h0, 1'b0, 3'd0});
  endtask

  // ---------------- main test ----------------
  initial begin : main
    vec_t va, vb, vc;
    rst = 1'b1;
    ifc.in_valid = 1'b0; ifc.out_ready = 1'b0;
    ifc.op = '0; ifc.rs1 = '0; ifc.rs2 = '0; ifc.rd = '0; ifc.func = '0; ifc.imm = '0;
    cur_exp = '0;

    vecs.push_back(mk("add",     OP_R,   1, 2, 3, F_ADD,  32'd0,         32'h002081B3, 0));
    vecs.push_back(mk("addi_m1", OP_I,   0, 0, 1, F_ADDI, 32'hFFFF_FFFF, 32'hFFF00093, 0));
    vecs.push_back(mk("sw",      OP_S,   2, 5, 0, F_SW,   32'd8,         32'h00512423, 0));
    vecs.push_back(mk("beq_m4",  OP_B,   1, 2, 0, F_BEQ,  32'hFFFF_FFFC, 32'hFE208EE3, 0));
    vecs.push_back(mk("jal",     OP_J,   0, 0, 1, 10'd0,  32'd2048,      32'h001000EF, 0));
    vecs.push_back(mk("sub",     OP_R,   2, 3, 1, F_SUB,  32'd0,         32'h403100B3, 0));
    vecs.push_back(mk("lui",     OP_U,   0, 0, 5, 10'd0,  32'h12345ABC,  32'h123452B7, 0));
    vecs.push_back(mk("lw_min",  OP_ILD, 4, 0, 3, F_LW,   32'hFFFF_F800, 32'h80022183, 0));
    vecs.push_back(mk("jalr",    OP_IJR, 5, 0, 1, F_JALR, 32'd0,         32'h000280E7, 0));
    vecs.push_back(mk("srai",    OP_I,   2, 0, 1, F_SRAI, 32'h0000_0405, 32'h40515093, 0));
    vecs.push_back(mk("slli31",  OP_I,   1, 0, 1, F_SLLI, 32'd31,        32'h01F09093, 0));
    vecs.push_back(mk("bne",     OP_B,   1, 2, 0, F_BNE,  32'd8,         32'h00209463, 0));
    vecs.push_back(mk("b_max",   OP_B,   0, 0, 0, F_BEQ,  32'd4094,      32'h7E000FE3, 0));
    vecs.push_back(mk("j_min",   OP_J,   0, 0, 0, 10'd0,  32'hFFF0_0000, 32'h8000006F, 0));
    vecs.push_back(mk("beq_odd", OP_B,   1, 2, 0, F_BEQ,  32'd3,         32'h0, ENC_ERR_ALIGN));
    vecs.push_back(mk("addi_2k", OP_I,   0, 0, 1, F_ADDI, 32'd2048,      32'h0, ENC_ERR_RANGE));
    vecs.push_back(mk("bad_op",  7'h7F,  0, 0, 0, 10'h3FF, 32'd1,        32'h0, ENC_ERR_OP));
    vecs.push_back(mk("srai_f7", OP_I,   2, 0, 1, 10'b0000001_101, 32'h0000_0405, 32'h0, ENC_ERR_FUNC));
    vecs.push_back(mk("b_4095",  OP_B,   0, 0, 0, F_BEQ,  32'd4095,      32'h0, ENC_ERR_RANGE));
    vecs.push_back(mk("b_4096",  OP_B,   0, 0, 0, F_BEQ,  32'd4096,      32'h0, ENC_ERR_RANGE));
    vecs.push_back(mk("j_odd",   OP_J,   0, 0, 1, 10'd0,  32'd1,         32'h0, ENC_ERR_ALIGN));
    vecs.push_back(mk("j_2pow20",OP_J,   0, 0, 1, 10'd0,  32'h0010_0000, 32'h0, ENC_ERR_RANGE));
    vecs.push_back(mk("jalr_f3", OP_IJR, 1, 0, 1, 10'b0000000_001, 32'd0, 32'h0, ENC_ERR_FUNC));
    vecs.push_back(mk("mul",     OP_R,   1, 2, 3, 10'b0000001_000, 32'd0, 32'h0, ENC_ERR_FUNC));
    vecs.push_back(mk("addi_f7", OP_I,   1, 0, 1, 10'b0000001_000, 32'd0, 32'h0, ENC_ERR_FUNC));
    vecs.push_back(mk("sw_low",  OP_S,   2, 5, 0, F_SW,   32'hFFFF_F7FF, 32'h0, ENC_ERR_RANGE));
    vecs.push_back(mk("lb_f3",   OP_ILD, 1, 0, 1, 10'b0000000_011, 32'd0, 32'h0, ENC_ERR_FUNC));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle("reset");
`ifdef ENC_STATS_EN
    check("reset_counters", {4'd0, n_ok, n_err}, 36'd0);
`endif
    @(posedge clk); #1;

    // First-word latency: visible right after the accepting edge
    ifc.out_ready = 1'b1;
    send(vecs[0], 1'b0);
    ifc.in_valid = 1'b0;
    @(negedge clk);
    check("latency", {3'd0, ifc.out_valid, ifc.instr}, {3'd0, 1'b1, 32'h002081B3});
    @(posedge clk); #1;
    drain("latency");

    // Table, streamed back-to-back with random output stalls
    foreach (vecs[i]) send(vecs[i], 1'b1);
    drain("table");
`ifdef ENC_STATS_EN
    check("n_ok",  {20'd0, n_ok},  36'(exp_ok));
    check("n_err", {20'd0, n_err}, 36'(exp_err));
`endif

    // Backpressure: A held, B in skid, C stalls
    va = vecs[1]; vb = vecs[2]; vc = vecs[3];
    ifc.out_ready = 1'b0;
    drive(va);
    @(negedge clk);
    check("bp_a_ready", {35'd0, ifc.in_ready}, 36'd1);
    @(posedge clk); #1;
    drive(vb);
    @(negedge clk);
    check("bp_out_a1", {3'd0, ifc.out_valid, ifc.instr}, {3'd0, 1'b1, va.e_instr});
    check("bp_b_ready", {35'd0, ifc.in_ready}, 36'd1);
    @(posedge clk); #1;
    drive(vc);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("bp_out_a_stable", {3'd0, ifc.out_valid, ifc.instr}, {3'd0, 1'b1, va.e_instr});
      check("bp_c_stalled", {35'd0, ifc.in_ready}, 36'd0);
      @(posedge clk); #1;
    end
    ifc.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ifc.in_ready) break;
    end
    @(posedge clk); #1;
    drain("bp");

    // Reset while the skid is full
    ifc.out_ready = 1'b0;
    drive(vecs[5]);
    @(posedge clk); #1;
    drive(vecs[6]);
    @(posedge clk); #1;
    ifc.in_valid = 1'b0;
    @(negedge clk);
    check("full_before_rst", {34'd0, ifc.out_valid, ifc.in_ready}, 36'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("mid_rst");
`ifdef ENC_STATS_EN
    check("mid_rst_counters", {4'd0, n_ok, n_err}, 36'd0);
`endif
    @(posedge clk); #1;
    ifc.out_ready = 1'b1;
    send(vecs[7], 1'b0);
    drain("after_rst");
`ifdef ENC_STATS_EN
    check("after_rst_n_ok", {20'd0, n_ok}, 36'd1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
